// File: rtl/digit_scanner.sv
// digit_scanner: time-multiplexed anode driver for a NUM_DIGITS-digit display.
// A prescaler divides clk into digit slots. At the end of each slot the scan
// steps to the next lit digit in digit_mask, wrapping past the top index.
// Optional build macro: DIGIT_SCANNER_BLANKING_EN. When it is defined, all
// anodes are held off for the first BLANK_CYCLES cycles of every slot to
// suppress ghosting. When it is undefined, the selected anode stays on for the
// whole slot.
module digit_scanner #(
    parameter int NUM_DIGITS   = 4,
    parameter int PRESCALE     = 100000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          enable,
    input  logic [NUM_DIGITS-1:0]         digit_mask,
    output logic [$clog2(NUM_DIGITS)-1:0] digit_sel,
    output logic [NUM_DIGITS-1:0]         anode_n,
    output logic                          scan_tick,
    output logic                          frame_done
);

    localparam int SEL_W = $clog2(NUM_DIGITS);
    localparam int PS_W  = $clog2(PRESCALE);

    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

    // Reject illegal configurations at elaboration time rather than
    // producing a scanner that silently misbehaves.
    if (NUM_DIGITS < 2 || NUM_DIGITS > 8) begin : g_bad_digits
        $error("digit_scanner: NUM_DIGITS must be in 2..8");
    end
    if (PRESCALE < 2 || PRESCALE > (1 << 24)) begin : g_bad_prescale
        $error("digit_scanner: PRESCALE must be in 2..2^24");
    end
    if (BLANK_CYCLES < 1 || BLANK_CYCLES >= PRESCALE) begin : g_bad_blank
        $error("digit_scanner: BLANK_CYCLES must be in 1..PRESCALE-1");
    end

    logic [PS_W-1:0]       presc_q, presc_d;
    logic [SEL_W-1:0]      sel_q, sel_d;
    logic [NUM_DIGITS-1:0] anode_q, anode_d;
    logic                  tick_q;
    logic                  frame_q;

    logic                  term;
    logic                  found;
    logic [SEL_W-1:0]      nxt_sel;
    logic                  wrap;
    logic                  blank_d;

    // The slot ends on the last prescaler count, and only while scanning runs.
    assign term = enable && (presc_q == PS_LAST);

    // Prescaler next value: wrap at the end of the slot, otherwise count up.
    always_comb begin
        presc_d = presc_q;
        if (enable) begin
            presc_d = term ? '0 : presc_q + 1'b1;
        end
    end

    // Find the next lit digit above the current one, searching cyclically.
    // Offsets are walked from the largest down, so the smallest offset that
    // hits a set mask bit wins. An offset of NUM_DIGITS lands on the current
    // digit, which covers the case where only one digit is lit.
    always_comb begin
        found   = 1'b0;
        nxt_sel = sel_q;
        for (int k = NUM_DIGITS; k >= 1; k--) begin
            if (digit_mask[(int'(sel_q) + k) % NUM_DIGITS]) begin
                found   = 1'b1;
                nxt_sel = SEL_W'((int'(sel_q) + k) % NUM_DIGITS);
            end
        end
    end

    // A frame ends when the scan lands on an index at or below the current
    // one. This includes the single-digit case, where the scan stays put.
    assign wrap = (nxt_sel <= sel_q);

    // Digit select next value: move only at end of slot and only if a
    // lit digit exists; an all-dark mask leaves the index where it was.
    always_comb begin
        sel_d = sel_q;
        if (term && found) begin
            sel_d = nxt_sel;
        end
    end

    // Blanking window is judged on the next prescaler value so that it lines
    // up with the registered anode outputs.
`ifdef DIGIT_SCANNER_BLANKING_EN
    always_comb begin
        blank_d = (presc_d < PS_W'(BLANK_CYCLES));
    end
`else
    always_comb begin
        blank_d = 1'b0;
    end
`endif

    // Anode decode: at most one bit low by construction. It is driven from the
    // next select value, so the anode changes on the same edge as digit_sel.
    // The live mask gates it, so clearing the current digit darkens it on
    // the next edge.
    always_comb begin
        anode_d = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if ((sel_d == SEL_W'(i)) && digit_mask[i] && !blank_d) begin
                anode_d[i] = 1'b0;
            end
        end
    end

    // Scanner state. Reset is asynchronous and discards any partial slot.
    // With enable low, everything holds and both pulses are suppressed.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc_q <= '0;
            sel_q   <= '0;
            anode_q <= '1;
            tick_q  <= 1'b0;
            frame_q <= 1'b0;
        end else if (enable) begin
            presc_q <= presc_d;
            sel_q   <= sel_d;
            anode_q <= anode_d;
            tick_q  <= term;
            frame_q <= term && found && wrap;
        end else begin
            tick_q  <= 1'b0;
            frame_q <= 1'b0;
        end
    end

    assign digit_sel  = sel_q;
    assign anode_n    = anode_q;
    assign scan_tick  = tick_q;
    assign frame_done = frame_q;

endmodule

// File: tb/tb_digit_scanner.sv
// Self-checking bench for digit_scanner (NUM_DIGITS=4, PRESCALE=4, BLANK_CYCLES=1).
// A behavioural model pushes the expected outputs for each cycle onto a
// scoreboard queue. Each scenario task pops that entry after the edge and
// compares it against the DUT.
module tb_digit_scanner;
    localparam int N = 4;
    localparam int P = 4;
    localparam int B = 1;
`ifdef DIGIT_SCANNER_BLANKING_EN
    localparam bit BLANK = 1'b1;
`else
    localparam bit BLANK = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset_n;
    logic       enable;
    logic [3:0] digit_mask;
    logic [1:0] digit_sel;
    logic [3:0] anode_n;
    logic       scan_tick;
    logic       frame_done;

    digit_scanner #(.NUM_DIGITS(N), .PRESCALE(P), .BLANK_CYCLES(B)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .enable     (enable),
        .digit_mask (digit_mask),
        .digit_sel  (digit_sel),
        .anode_n    (anode_n),
        .scan_tick  (scan_tick),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] sel;
        logic [3:0] an;
        logic       tick;
        logic       fd;
    } obs_t;

    obs_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Model state: prescaler, current digit, and registered anode.
    int         mp = 0;
    int         ms = 0;
    logic [3:0] m_an = 4'hF;

    function automatic obs_t observe();
        obs_t o;
        o.sel  = digit_sel;
        o.an   = anode_n;
        o.tick = scan_tick;
        o.fd   = frame_done;
        return o;
    endfunction

    task automatic model_reset();
        mp   = 0;
        ms   = 0;
        m_an = 4'hF;
        sb.delete();
    endtask

    // Predict the outcome of the coming edge, queue it, then advance to
    // just after that edge.
    task automatic step();
        obs_t e;
        bit   tc;
        bit   found;
        int   nxt;
        tc     = enable && (mp == P - 1);
        e.tick = tc;
        e.fd   = 1'b0;
        if (enable) mp = (mp == P - 1) ? 0 : mp + 1;
        if (tc) begin
            found = 1'b0;
            nxt   = ms;
            for (int k = 1; k <= N; k++) begin
                if (!found && digit_mask[(ms + k) % N]) begin
                    found = 1'b1;
                    nxt   = (ms + k) % N;
                end
            end
            if (found) begin
                e.fd = (nxt <= ms);
                ms   = nxt;
            end
        end
        if (enable) begin
            m_an = 4'hF;
            if (digit_mask[ms] && !(BLANK && mp < B)) m_an[ms] = 1'b0;
        end
        e.sel = 2'(ms);
        e.an  = m_an;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        obs_t exp_o;
        exp_o = '{sel: 2'd0, an: 4'hF, tick: 1'b0, fd: 1'b0};
        #2;
        n_cmp++;
        if (observe() !== exp_o) begin
            n_bad++;
            $display("FAIL reset_async: got %h exp %h", observe(), exp_o);
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (observe() !== exp_o) begin
            n_bad++;
            $display("FAIL reset_held: got %h exp %h", observe(), exp_o);
        end
        reset_n = 1'b1;
        model_reset();
    endtask

    task automatic test_full_scan();
        obs_t e;
        int   fd_cnt = 0;
        int   nt     = 0;
        int   seq[5] = '{1, 2, 3, 0, 1};
        digit_mask = 4'b1111;
        for (int c = 0; c < 20; c++) begin
            step();
            e = sb.pop_front();
            n_cmp++;
            if (observe() !== e) begin
                n_bad++;
                $display("FAIL full_scan cyc %0d: got %h exp %h", c, observe(), e);
            end
            if (frame_done) fd_cnt++;
            if (scan_tick) begin
                n_cmp++;
                if (nt > 4 || int'(digit_sel) != seq[nt]) begin
                    n_bad++;
                    $display("FAIL full_scan_seq tick %0d: got sel=%0d", nt, digit_sel);
                end
                nt++;
            end
        end
        n_cmp++;
        if (fd_cnt != 1 || nt != 5) begin
            n_bad++;
            $display("FAIL full_scan_counts: got fd=%0d ticks=%0d exp fd=1 ticks=5", fd_cnt, nt);
        end
    endtask

    task automatic test_two_digit();
        obs_t e;
        int   fd_cnt = 0;
        bit   bad_an = 1'b0;
        digit_mask = 4'b1010;
        for (int c = 0; c < 24; c++) begin
            step();
            e = sb.pop_front();
            n_cmp++;
            if (observe() !== e) begin
                n_bad++;
                $display("FAIL two_digit cyc %0d: got %h exp %h", c, observe(), e);
            end
            if (frame_done) fd_cnt++;
            if (anode_n == 4'b1110 || anode_n == 4'b1011) bad_an = 1'b1;
        end
        n_cmp++;
        if (fd_cnt != 3 || bad_an) begin
            n_bad++;
            $display("FAIL two_digit_summary: got fd=%0d unlit_anode=%0d exp fd=3 unlit_anode=0", fd_cnt, bad_an);
        end
    endtask

    task automatic test_no_digit();
        obs_t e;
        int   nt = 0;
        digit_mask = 4'b0000;
        for (int c = 0; c < 12; c++) begin
            step();
            e = sb.pop_front();
            n_cmp++;
            if (observe() !== e || anode_n !== 4'hF || frame_done !== 1'b0) begin
                n_bad++;
                $display("FAIL no_digit cyc %0d: got %h exp %h", c, observe(), e);
            end
            if (scan_tick) nt++;
        end
        n_cmp++;
        if (nt != 3) begin
            n_bad++;
            $display("FAIL no_digit_ticks: got %0d exp 3", nt);
        end
    endtask

    task automatic test_single_digit();
        obs_t e;
        digit_mask = 4'b0100;
        for (int c = 0; c < 12; c++) begin
            step();
            e = sb.pop_front();
            n_cmp++;
            if (observe() !== e) begin
                n_bad++;
                $display("FAIL single_digit cyc %0d: got %h exp %h", c, observe(), e);
            end
        end
    endtask

    task automatic test_enable_freeze();
        obs_t e;
        digit_mask = 4'b1111;
        for (int c = 0; c < 22; c++) begin
            enable = !(c >= 2 && c < 12);
            step();
            e = sb.pop_front();
            n_cmp++;
            if (observe() !== e) begin
                n_bad++;
                $display("FAIL enable_freeze cyc %0d: got %h exp %h", c, observe(), e);
            end
        end
        enable = 1'b1;
    endtask

    task automatic test_mask_clear();
        obs_t e;
        digit_mask = 4'b1111;
        for (int c = 0; c < 10; c++) begin
            if (c == 6) digit_mask[ms] = 1'b0;
            step();
            e = sb.pop_front();
            n_cmp++;
            if (observe() !== e) begin
                n_bad++;
                $display("FAIL mask_clear cyc %0d: got %h exp %h", c, observe(), e);
            end
        end
    endtask

    task automatic test_async_reset();
        obs_t e;
        obs_t exp_o;
        exp_o      = '{sel: 2'd0, an: 4'hF, tick: 1'b0, fd: 1'b0};
        digit_mask = 4'b1111;
        for (int c = 0; c < 6; c++) begin
            step();
            e = sb.pop_front();
        end
        reset_n = 1'b0;
        #1;
        n_cmp++;
        if (observe() !== exp_o) begin
            n_bad++;
            $display("FAIL async_reset: got %h exp %h", observe(), exp_o);
        end
        #2;
        reset_n = 1'b1;
        model_reset();
        for (int c = 0; c < 10; c++) begin
            step();
            e = sb.pop_front();
            n_cmp++;
            if (observe() !== e) begin
                n_bad++;
                $display("FAIL after_reset cyc %0d: got %h exp %h", c, observe(), e);
            end
        end
    endtask

    task automatic test_random();
        obs_t e;
        for (int c = 0; c < 300; c++) begin
            digit_mask = ($urandom_range(0, 7) == 0) ? 4'($urandom) : digit_mask;
            enable     = ($urandom_range(0, 4) != 0);
            step();
            e = sb.pop_front();
            n_cmp++;
            if (observe() !== e || $countones(~anode_n) > 1) begin
                n_bad++;
                $display("FAIL random cyc %0d: got %h exp %h", c, observe(), e);
            end
        end
        enable = 1'b1;
    endtask

    initial begin
        reset_n    = 1'b1;
        enable     = 1'b1;
        digit_mask = 4'b1111;
        #1;
        reset_n = 1'b0;
        test_reset();
        test_full_scan();
        test_two_digit();
        test_no_digit();
        test_single_digit();
        test_enable_freeze();
        test_mask_clear();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/digit_scanner.md
DIGIT_SCANNER -- requirements
Module: digit_scanner

Interface
REQ-001 Parameter NUM_DIGITS, default 4, number of multiplexed digits; legal range 2..8.
REQ-002 Parameter PRESCALE, default 100000, clk cycles per digit slot; legal range 2..2^24.
REQ-003 Parameter BLANK_CYCLES, default 16, anode-off cycles at slot start; legal range 1..PRESCALE-1.
REQ-004 Derived SEL_W = clog2(NUM_DIGITS); PS_W = clog2(PRESCALE).
REQ-005 clk  input  1  system clock; all state updates on its rising edge.
REQ-006 reset_n  input  1  reset, asynchronous and active-low.
REQ-007 enable  input  1  1 = scanning runs; 0 = all state frozen.
REQ-008 digit_mask  input  NUM_DIGITS  bit i = 1: digit i is lit and visited by the scan.
REQ-009 digit_sel  output  SEL_W  index of the current digit, for segment-data muxing.
REQ-010 anode_n  output  NUM_DIGITS  registered, active-low anode drive, at most one bit low.
REQ-011 scan_tick  output  1  one-cycle pulse on the cycle digit_sel takes a new value.
REQ-012 frame_done  output  1  one-cycle pulse, coincident with scan_tick, when the scan wraps.

Function
REQ-013 The prescaler counts 0..PRESCALE-1 while enable=1, wrapping to 0; it holds while enable=0.
REQ-014 At prescaler terminal count (PRESCALE-1, enable=1), digit_sel moves on the next edge to the next index above the current one whose digit_mask bit is 1, searching cyclically with wrap past NUM_DIGITS-1 to 0.
REQ-015 If the current index is the only set mask bit, digit_sel keeps its value and scan_tick still pulses.
REQ-016 If digit_mask is all zero at terminal count, digit_sel holds, scan_tick pulses, frame_done stays 0, and anode_n stays all ones.
REQ-017 frame_done pulses when the selected next index is less than or equal to the current index (wrap), including the single-digit case of REQ-015.
REQ-018 anode_n[i] is 0 exactly when digit_sel==i, digit_mask[i] (sampled the previous cycle) is 1, and the slot is not blanking; it has one cycle of latency from digit_mask and is aligned with digit_sel.
REQ-019 Clearing the current digit's mask bit mid-slot darkens it within one cycle; digit_sel moves only at the next terminal count.
REQ-020 While enable=0: digit_sel, the prescaler and anode_n hold; scan_tick and frame_done are 0.
REQ-021 Never more than one anode_n bit is low in any cycle, including across transitions.

Reset
REQ-022 Asserting reset_n=0 immediately forces prescaler=0, digit_sel=0, anode_n=all ones, scan_tick=0 and frame_done=0, regardless of clk.
REQ-023 After reset release, the first terminal count occurs PRESCALE enabled cycles later; reset mid-slot discards the partial slot.

Configuration
REQ-024 Macro DIGIT_SCANNER_BLANKING_EN defined: anode_n is all ones while prescaler < BLANK_CYCLES in each slot (anti-ghosting).
REQ-025 Macro DIGIT_SCANNER_BLANKING_EN undefined: BLANK_CYCLES is ignored and the selected anode is driven for the whole slot.

Verification (NUM_DIGITS=4, PRESCALE=4, BLANK_CYCLES=1, enable=1 unless stated)
REQ-026 mask=4'b1111, release reset -> digit_sel 0,1,2,3,0 every 4 clks; frame_done only on the 3->0 step; anode_n cycles 1110,1101,1011,0111.
REQ-027 mask=4'b1010 -> digit_sel alternates 1,3,1,3; frame_done on each 3->1 step; anode_n never 1110 or 1011.
REQ-028 mask=4'b0000 -> anode_n=1111 constantly, digit_sel held, scan_tick every 4 clks, frame_done never.
REQ-029 enable=0 for 10 clks mid-slot -> prescaler, digit_sel and anode_n frozen and no pulses; the slot resumes with the remaining count.
REQ-030 BLANKING_EN defined -> anode_n=1111 for the first clk of every slot; undefined -> no blank cycle; reset_n pulsed low mid-slot -> anode_n=1111 and digit_sel=0 asynchronously.
